// File: rtl/serial_bus_initiator_pkg.sv
// Shared definitions for the serial bus initiator: command/response codes,
// FSM state encoding and response byte-count helpers.
package serial_bus_initiator_pkg;

  localparam logic [7:0] CMD_WRITE     = 8'h57;
  localparam logic [7:0] CMD_READ      = 8'h52;

  localparam logic [7:0] RESP_OK       = 8'h4B;
  localparam logic [7:0] RESP_MISALIGN = 8'h45;
  localparam logic [7:0] RESP_UNKNOWN  = 8'h3F;

  // Response byte count is 1 or 4, so three bits are enough.
  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_ONE  = 3'd1;
  localparam logic [CNT_W-1:0] CNT_FOUR = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_BUS  = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  // Index of the first byte to send: a 4-byte response starts at the MSB
  // (index 0), a 1-byte response sends only the LSB (index 3).
  function automatic logic [1:0] start_index(input logic [CNT_W-1:0] count);
    logic [CNT_W-1:0] s;
    s = 3'd4 - count;
    return s[1:0];
  endfunction

  // Byte of a word by index, index 0 being the most significant byte.
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      2'd3:    b = word[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/serial_bus_initiator_resp_serializer.sv
// Response serializer: loads a word and a byte count, then presents the bytes
// MSB first on a valid/ready transmit interface. done pulses in the cycle the
// last byte is accepted.
module serial_bus_initiator_resp_serializer
  import serial_bus_initiator_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [31:0]      load_word,
  input  logic [CNT_W-1:0] load_count,
  input  logic             tx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  output logic             done
);

  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic        active_q, active_d;
  logic [7:0]  data_q, data_d;

  // Next-state: load a new word, or advance one byte per accepted transfer.
  always_comb begin
    word_d   = word_q;
    idx_d    = idx_q;
    active_d = active_q;
    data_d   = data_q;
    done     = 1'b0;
    if (load) begin
      word_d   = load_word;
      idx_d    = start_index(load_count);
      active_d = 1'b1;
      data_d   = word_byte(load_word, idx_d);
    end else if (active_q && tx_ready) begin
      if (idx_q == 2'd3) begin
        active_d = 1'b0;
        done     = 1'b1;
      end else begin
        idx_d  = idx_q + 2'd1;
        data_d = word_byte(word_q, idx_d);
      end
    end else begin
      // Waiting for a load or for the transmitter; hold the current byte.
      active_d = active_q;
    end
  end

  // Serializer state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q   <= 32'd0;
      idx_q    <= 2'd0;
      active_q <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      word_q   <= word_d;
      idx_q    <= idx_d;
      active_q <= active_d;
      data_q   <= data_d;
    end
  end

  assign tx_data  = data_q;
  assign tx_valid = active_q;

endmodule

// File: rtl/serial_bus_initiator.sv
// Serial bus initiator: decodes read/write command frames from a UART byte
// stream, performs one bus access while holding the CPU off the bus, and
// returns the result bytes through the response serializer.
module serial_bus_initiator
  import serial_bus_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        hold,
  output logic        rd,
  output logic        wr,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata
);

  localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  state_t      state_q, state_d;
  logic        is_write_q, is_write_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] addr_shift_q, addr_shift_d;
  logic [31:0] data_shift_q, data_shift_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        hold_q, hold_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;

  logic             load_s;
  logic [31:0]      load_word_s;
  logic [CNT_W-1:0] load_count_s;
  logic             done_s;

  // Command FSM: frame decode, timeout, bus access and response hand-off.
  // Strobes and hold are registered from the next state so that they line
  // up exactly with the state they belong to.
  always_comb begin
    state_d      = state_q;
    is_write_d   = is_write_q;
    byte_cnt_d   = byte_cnt_q;
    addr_shift_d = addr_shift_q;
    data_shift_d = data_shift_q;
    timer_d      = timer_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    load_s       = 1'b0;
    load_word_s  = 32'd0;
    load_count_s = CNT_ONE;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          if ((rx_data == CMD_WRITE) || (rx_data == CMD_READ)) begin
            is_write_d = (rx_data == CMD_WRITE);
            byte_cnt_d = 2'd0;
            timer_d    = 32'd0;
            state_d    = ST_ADDR;
          end else begin
            load_s      = 1'b1;
            load_word_s = {24'd0, RESP_UNKNOWN};
            state_d     = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ADDR: begin
        if (rx_valid) begin
          addr_shift_d = {addr_shift_q[23:0], rx_data};
          timer_d      = 32'd0;
          if (byte_cnt_q == 2'd3) begin
            byte_cnt_d = 2'd0;
            if (rx_data[1:0] != 2'b00) begin
              load_s      = 1'b1;
              load_word_s = {24'd0, RESP_MISALIGN};
              state_d     = ST_RESP;
            end else if (is_write_q) begin
              state_d = ST_DATA;
            end else begin
              addr_d  = addr_shift_d;
              state_d = ST_BUS;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else if (TIMEOUT_EN && (timer_q == TIMEOUT_LAST)) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      ST_DATA: begin
        if (rx_valid) begin
          data_shift_d = {data_shift_q[23:0], rx_data};
          timer_d      = 32'd0;
          if (byte_cnt_q == 2'd3) begin
            byte_cnt_d = 2'd0;
            addr_d     = addr_shift_q;
            wdata_d    = data_shift_d;
            state_d    = ST_BUS;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else if (TIMEOUT_EN && (timer_q == TIMEOUT_LAST)) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      ST_BUS: begin
        // rdata is valid while rd is high; the serializer captures it now.
        load_s       = 1'b1;
        load_word_s  = is_write_q ? {24'd0, RESP_OK} : rdata;
        load_count_s = is_write_q ? CNT_ONE : CNT_FOUR;
        state_d      = ST_RESP;
      end

      ST_RESP: begin
        if (done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    hold_d = (state_d == ST_ADDR) || (state_d == ST_DATA) || (state_d == ST_BUS);
    rd_d   = (state_d == ST_BUS) && !is_write_d;
    wr_d   = (state_d == ST_BUS) && is_write_d;
  end

  // FSM and bus-output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      is_write_q   <= 1'b0;
      byte_cnt_q   <= 2'd0;
      addr_shift_q <= 32'd0;
      data_shift_q <= 32'd0;
      timer_q      <= 32'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      hold_q       <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_write_q   <= is_write_d;
      byte_cnt_q   <= byte_cnt_d;
      addr_shift_q <= addr_shift_d;
      data_shift_q <= data_shift_d;
      timer_q      <= timer_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      hold_q       <= hold_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
    end
  end

  serial_bus_initiator_resp_serializer u_resp_serializer (
    .clk        (clk),
    .reset      (reset),
    .load       (load_s),
    .load_word  (load_word_s),
    .load_count (load_count_s),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .done       (done_s)
  );

  assign hold  = hold_q;
  assign rd    = rd_q;
  assign wr    = wr_q;
  assign addr  = addr_q;
  assign wdata = wdata_q;

endmodule
